// File: rtl/port_out_pkt_buffer.sv
// port_out_pkt_buffer
//   Per-port store-and-forward output buffer. Bytes from the switch core are
//   written speculatively. A packet becomes visible to the port only after its
//   last byte has been written. A packet that does not fit is rewound and
//   discarded whole, and drop_cnt counts it.
// Ports
//   clk, rst_n          port clock, asynchronous active-low reset
//   in_valid/in_data    byte from the switch core
//   in_last             marks the final byte of a packet
//   data, ready         head committed byte (8'h00 when ready=0) and availability
//   read                pops the head byte at this posedge
//   drop_cnt            packets discarded on overflow, saturating
//   rd_err              sticky flag: read seen while ready=0
module port_out_pkt_buffer #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic [7:0]       data,
    output logic             ready,
    input  logic             read,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             rd_err
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int PW   = ADDR + 1;

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, used;
    logic          full, wr_en;

    // Fullness comes from registered pointers only, so a pop in the same
    // cycle does not make room for an incoming byte.
    always_comb begin
        used  = wr_ptr - rd_ptr;
        full  = (used == PW'(DEPTH));
        wr_en = in_valid && !full && (state != DROP);
        ready = (rd_ptr != commit_ptr);
        data  = ready ? mem[rd_ptr[ADDR-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            drop_cnt   <= '0;
            rd_err     <= 1'b0;
        end else begin
            if (read) begin
                if (ready) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end else begin
                    rd_err <= 1'b1;
                end
            end

            case (state)
                IDLE, RECV: begin
                    if (in_valid) begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + PW'(1);
                            if (in_last) begin
                                commit_ptr <= wr_ptr + PW'(1);
                                state      <= IDLE;
                            end else begin
                                state      <= RECV;
                            end
                        end else begin
                            // Rewind the partial packet; committed bytes are untouched.
                            wr_ptr <= commit_ptr;
                            if (drop_cnt != '1) begin
                                drop_cnt <= drop_cnt + CNT_W'(1);
                            end
                            state <= in_last ? IDLE : DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_valid && in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_out_pkt_buffer.sv
module tb_port_out_pkt_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic [7:0]       data;
    logic             ready;
    logic             read = 1'b0;
    logic [CNT_W-1:0] drop_cnt;
    logic             rd_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    logic [7:0] pend[$];
    logic [7:0] exp_q[$];

    port_out_pkt_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .data(data), .ready(ready), .read(read),
        .drop_cnt(drop_cnt), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT will perform at the next posedge is compared
    // with the head of the expected-byte queue.
    always @(negedge clk) begin
        if (rst_n && ready && read) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no committed byte", data);
            end else begin
                check("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Drive pkt byte by byte. Expected bytes are queued when the last byte is
    // issued and keep=1. With rd=1 the consumer pops whenever ready.
    task automatic send(input bit last, input bit keep, input bit rd);
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = last && (i == pkt.size() - 1);
            read     = rd ? ready : 1'b0;
            pend.push_back(pkt[i]);
            if (in_last) begin
                if (keep) begin
                    foreach (pend[j]) exp_q.push_back(pend[j]);
                end
                pend.delete();
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        read     = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            read = ready;
            if (!ready && exp_q.size() == 0) break;
        end
        read = 1'b0;
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_ready_low", {31'h0, ready}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        // 1: reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", {31'h0, ready}, 0);
        check("rst_data", {24'h0, data}, 0);
        check("rst_drop_cnt", {30'h0, drop_cnt}, 0);
        check("rst_rd_err", {31'h0, rd_err}, 0);

        // 2: three-byte packet, ready one cycle after last byte is written
        pkt = '{8'hA5, 8'h01, 8'h02};
        send(1, 1, 0);
        check("t2_ready", {31'h0, ready}, 1);
        check("t2_head", {24'h0, data}, 32'hA5);
        drain();

        // 3: uncommitted bytes stay hidden across a gap
        pkt = '{8'h11, 8'h22};
        send(0, 1, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t3_ready_hold", {31'h0, ready}, 0);
        check("t3_data_zero", {24'h0, data}, 0);
        pkt = '{8'h33};
        send(1, 1, 0);
        drain();

        // 4: packet longer than DEPTH is dropped, next packet intact
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(8'(i));
        send(1, 0, 0);
        check("t4_drop_cnt", {30'h0, drop_cnt}, 1);
        check("t4_ready", {31'h0, ready}, 0);
        pkt = '{8'h7E, 8'h7F};
        send(1, 1, 0);
        drain();

        // 5: read on empty buffer
        @(posedge clk); #1 read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
        check("t5_rd_err", {31'h0, rd_err}, 1);
        check("t5_ready", {31'h0, ready}, 0);
        check("t5_data", {24'h0, data}, 0);

        // 6a: back-to-back packets with reads overlapping writes
        pkt = '{8'hC1, 8'hC2, 8'hC3};
        send(1, 1, 1);
        pkt = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        send(1, 1, 1);
        drain();

        // 6b: exact-fit packet, then a write while full with a read in the same cycle
        pkt = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        send(1, 1, 0);
        check("t6_fullpkt_head", {24'h0, data}, 32'h80);
        pkt = '{8'hF0, 8'hF1};
        send(1, 0, 1);
        check("t6_full_drop_cnt", {30'h0, drop_cnt}, 2);
        drain();

        // 6c: overflow on the last byte and counter saturation
        pkt.delete();
        for (int i = 0; i < 9; i++) pkt.push_back(8'(8'h40 + i));
        send(1, 0, 0);
        check("t6_drop_cnt_3", {30'h0, drop_cnt}, 3);
        send(1, 0, 0);
        check("t6_drop_cnt_sat", {30'h0, drop_cnt}, 3);
        check("t6_ready_after_drops", {31'h0, ready}, 0);
        check("t6_rd_err_sticky", {31'h0, rd_err}, 1);

        // 6d: reset pulse mid-packet discards committed and partial data
        pkt = '{8'hA0, 8'hA1};
        send(1, 1, 0);
        check("t6_pre_rst_ready", {31'h0, ready}, 1);
        pkt = '{8'hB0};
        send(0, 1, 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        pend.delete();
        #1;
        check("t6_rst_ready", {31'h0, ready}, 0);
        check("t6_rst_data", {24'h0, data}, 0);
        check("t6_rst_drop_cnt", {30'h0, drop_cnt}, 0);
        check("t6_rst_rd_err", {31'h0, rd_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        pkt = '{8'h5A};
        send(1, 1, 0);
        check("t6_post_rst_ready", {31'h0, ready}, 1);
        check("t6_post_rst_head", {24'h0, data}, 32'h5A);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
